rr_arbiter8: RTL and testbench

Round-robin arbiter that shares one resource between eight requesters and reports the winner both as a one-hot grant and as a 3-bit index, the same 8-to-3 one-hot encoding the team's encoder produces. Grants are registered, held until the owner releases or a hold timeout expires, and priority rotates past the last owner so every active requester is served within eight grants. It sits in front of any shared single-port unit in the CPU datapath (bus port, multiplier, debug port).

---
 rtl/rr_arbiter8.sv | 108 ++++++++++
 tb/tb_rr_arbiter8.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant and index.
// Grants are held until done, withdrawal, or the hold counter expires.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HLAST = HW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [7:0]    gnt_q, gnt_d;
    logic [2:0]    own_q, own_d;
    logic          tmo_q, tmo_d;

    logic [7:0]    rot;
    logic [2:0]    off;
    logic [2:0]    pick;
    logic          found;
    logic          rel;

    // Rotate so ptr lands on bit 0; lowest set bit is then the winner.
    assign rot   = 8'({req, req} >> ptr_q);
    assign found = |req;
    assign pick  = ptr_q + off;

    always_comb begin
        off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (rot[k]) begin
                off = 3'(k);
            end
        end
    end

    assign rel = done || !req[own_q] || (hcnt_q == HLAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        gnt_d   = gnt_q;
        own_d   = own_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = 8'b1 << pick;
                    own_d   = pick;
                    hcnt_d  = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    state_d = IDLE;
                    gnt_d   = 8'b0;
                    own_d   = 3'd0;
                    hcnt_d  = '0;
                    ptr_d   = own_q + 3'd1;
                    tmo_d   = !done && req[own_q];
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            hcnt_q  <= '0;
            gnt_q   <= 8'b0;
            own_q   <= 3'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
            gnt_q   <= gnt_d;
            own_q   <= own_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = own_q;
    assign gnt_valid = (state_q == GRANT);
    assign timeout   = tmo_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed table-driven bench for rr_arbiter8 (MAX_HOLD = 16).
// Each row: inputs for one cycle, expected outputs just after the edge.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    rr_arbiter8 #(.MAX_HOLD(16)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rstn;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       tmo;
    } vec_t;

    vec_t tab[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic add(input string nm, input logic rs,
                       input logic [7:0] rq, input logic dn,
                       input logic [7:0] g, input logic [2:0] ix,
                       input logic v, input logic t);
        vec_t r;
        r.name = nm;
        r.rstn = rs;
        r.req  = rq;
        r.done = dn;
        r.gnt  = g;
        r.idx  = ix;
        r.vld  = v;
        r.tmo  = t;
        tab.push_back(r);
    endtask

    task automatic step(input logic rs, input logic [7:0] rq,
                        input logic dn);
        @(negedge clk);
        resetn = rs;
        req    = rq;
        done   = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] g,
                       input logic [2:0] ix, input logic v,
                       input logic t);
        nvec++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== {g, ix, v, t}) begin
            nerr++;
            $display("FAIL %s: got gnt=%b idx=%0d vld=%b tmo=%b, want gnt=%b idx=%0d vld=%b tmo=%b",
                     nm, gnt, gnt_idx, gnt_valid, timeout, g, ix, v, t);
        end
    endtask

    initial begin
        int cnt;
        resetn = 1'b0;
        req    = 8'h00;
        done   = 1'b0;

        // reset with all requests active
        for (int i = 0; i < 3; i++)
            add("reset", 0, 8'hFF, 0, 8'h00, 0, 0, 0);
        add("rst_first", 1, 8'hFF, 0, 8'h01, 0, 1, 0);
        add("rst_done", 1, 8'hFF, 1, 8'h00, 0, 0, 0);

        // rotation 1..7 then wrap to 0
        for (int i = 1; i <= 8; i++) begin
            add("rot_gnt", 1, 8'hFF, 0, 8'h01 << (i % 8), 3'(i % 8), 1, 0);
            add("rot_rel", 1, 8'hFF, 1, 8'h00, 0, 0, 0);
        end

        // one requester per code, held 3 cycles
        for (int i = 0; i < 8; i++) begin
            add("single_g", 1, 8'h01 << i, 0, 8'h01 << i, 3'(i), 1, 0);
            add("single_h", 1, 8'h01 << i, 0, 8'h01 << i, 3'(i), 1, 0);
            add("single_h", 1, 8'h01 << i, 0, 8'h01 << i, 3'(i), 1, 0);
            add("single_r", 1, 8'h01 << i, 1, 8'h00, 0, 0, 0);
        end

        // wrap and skip from ptr=6
        add("wrap_own5", 1, 8'h20, 0, 8'h20, 5, 1, 0);
        add("wrap_rel5", 1, 8'h20, 1, 8'h00, 0, 0, 0);
        add("wrap_to0", 1, 8'h21, 0, 8'h01, 0, 1, 0);
        add("wrap_rel0", 1, 8'h21, 1, 8'h00, 0, 0, 0);
        add("wrap_to5", 1, 8'h21, 0, 8'h20, 5, 1, 0);
        add("wrap_rel5b", 1, 8'h21, 1, 8'h00, 0, 0, 0);

        // forced release after 16 cycles
        add("to_gnt", 1, 8'h08, 0, 8'h08, 3, 1, 0);
        for (int i = 0; i < 15; i++)
            add("to_hold", 1, 8'h08, 0, 8'h08, 3, 1, 0);
        add("to_pulse", 1, 8'h08, 0, 8'h00, 0, 0, 1);
        add("to_regnt", 1, 8'h08, 0, 8'h08, 3, 1, 0);
        for (int i = 0; i < 15; i++)
            add("to_hold2", 1, 8'h08, 0, 8'h08, 3, 1, 0);
        add("to_done16", 1, 8'h08, 1, 8'h00, 0, 0, 0);

        // withdrawal, ptr=4 so only bit 2 competes
        add("wd_gnt", 1, 8'h04, 0, 8'h04, 2, 1, 0);
        for (int i = 0; i < 3; i++)
            add("wd_hold", 1, 8'h05, 0, 8'h04, 2, 1, 0);
        add("wd_drop", 1, 8'h91, 0, 8'h00, 0, 0, 0);
        add("wd_next", 1, 8'h91, 0, 8'h10, 4, 1, 0);

        // reset mid-grant sends ptr back to 0
        add("mr_hold", 1, 8'h91, 0, 8'h10, 4, 1, 0);
        add("mr_reset", 0, 8'h91, 0, 8'h00, 0, 0, 0);
        add("mr_ptr0", 1, 8'h91, 0, 8'h01, 0, 1, 0);
        add("mr_rel", 1, 8'h91, 1, 8'h00, 0, 0, 0);

        foreach (tab[i]) begin
            step(tab[i].rstn, tab[i].req, tab[i].done);
            chk(tab[i].name, tab[i].gnt, tab[i].idx,
                tab[i].vld, tab[i].tmo);
        end

        // count hold length directly, with a cycle budget
        step(1, 8'h80, 0);
        chk("seq_gnt7", 8'h80, 7, 1, 0);
        cnt = 1;
        for (int b = 0; b < 40; b++) begin
            step(1, 8'h80, 0);
            if (!gnt_valid) break;
            cnt++;
        end
        chk("seq_tmo", 8'h00, 0, 0, 1);
        nvec++;
        if (cnt != 16) begin
            nerr++;
            $display("FAIL seq_len: got %0d cycles, want 16", cnt);
        end

        // reset coincident with forced release
        step(1, 8'h80, 0);
        chk("seq_regnt", 8'h80, 7, 1, 0);
        for (int i = 0; i < 15; i++)
            step(1, 8'h80, 0);
        chk("seq_last", 8'h80, 7, 1, 0);
        step(0, 8'h80, 0);
        chk("seq_rst_wins", 8'h00, 0, 0, 0);
        step(1, 8'h81, 0);
        chk("seq_ptr0", 8'h01, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
